// File: rtl/vector_sequencer_pkg.sv
// Shared opcode constants, state encoding and decode helpers
// for the vector instruction sequencer.
package vector_sequencer_pkg;

    localparam logic [6:0] V_MAJOR_OP_V    = 7'h57;
    localparam logic [6:0] V_MAJOR_LOAD_FP = 7'h07;
    localparam logic [2:0] V_OPCFG         = 3'b111;
    localparam logic [2:0] V_OPMVV         = 3'b010;
    localparam logic [2:0] V_LOAD_F3       = 3'b111;

    localparam logic [5:0] F6_VREDSUM  = 6'b000000;
    localparam logic [5:0] F6_VREDMAX  = 6'b000111;
    localparam logic [5:0] F6_VWREDSUM = 6'b110001;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_RUN
    } seq_state_t;

    function automatic logic is_reduction(
        logic [2:0] f3,
        logic [5:0] f6
    );
        return (f3 == V_OPMVV &&
                (f6 == F6_VREDSUM || f6 == F6_VREDMAX)) ||
               f6 == F6_VWREDSUM;
    endfunction

endpackage

// File: rtl/vector_sequencer_if.sv
// APU request/response bundle between the core and the
// vector sequencer.
interface vector_sequencer_if;

    logic             apu_req;
    logic             apu_gnt;
    logic [2:0][31:0] apu_operands;
    logic             apu_rvalid;
    logic             apu_err;

    modport master (
        output apu_req,
        output apu_operands,
        input  apu_gnt,
        input  apu_rvalid,
        input  apu_err
    );

    modport slave (
        input  apu_req,
        input  apu_operands,
        output apu_gnt,
        output apu_rvalid,
        output apu_err
    );

endinterface

// File: rtl/vector_instr_fifo.sv
// Synchronous instruction queue holding the instruction word
// and both scalar operands of each pending instruction.
module vector_instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/vector_sequencer.sv
// Queues APU instructions and expands the head instruction
// into LANES-wide beats with addresses and element masks.
module vector_sequencer
    import vector_sequencer_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int VL_WIDTH    = 5,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                clk,
    input  logic                n_reset,
    vector_sequencer_if.slave   apu,
    input  logic [VL_WIDTH-1:0] vl,
    output logic                beat_valid,
    output logic                beat_first,
    output logic                beat_last,
    output logic [31:0]         instr_word,
    output logic [31:0]         scalar_operand1,
    output logic [31:0]         scalar_operand2,
    output logic [4:0]          vs1_addr,
    output logic [4:0]          vs2_addr,
    output logic [4:0]          vd_addr,
    output logic [LANES-1:0]    elem_en,
    output logic                csr_write,
    output logic                vlsu_en,
    input  logic                vlsu_ready,
    output logic                busy
);

    localparam int LW = $clog2(LANES);
    localparam int BW =
        $clog2((2**VL_WIDTH - 1 + LANES - 1) / LANES) + 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    typedef logic [VL_WIDTH:0] vlx_t;

    logic [95:0]         head;
    logic                full;
    logic                empty;
    logic [CW-1:0]       count;
    logic                push;
    logic                pop;
    seq_state_t          state_q;
    seq_state_t          state_d;
    logic [BW-1:0]       cnt_q;
    logic [BW-1:0]       cnt_d;
    logic [VL_WIDTH-1:0] vl_q;
    logic [VL_WIDTH-1:0] vl_eff;
    logic [31:0]         word;
    logic                is_cfg;
    logic                is_load;
    logic                is_arith;
    logic                is_red;
    logic                is_err;
    logic                single;
    logic                valid;
    logic                last;
    logic                done;
    vlx_t                beats;
    vlx_t                rem;
    logic [LANES-1:0]    mask;
    logic [4:0]          off;

    assign push        = apu.apu_req && apu.apu_gnt;
    assign apu.apu_gnt = !full;

    vector_instr_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (96),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .pop     (pop),
        .wdata   (apu.apu_operands),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign word     = head[31:0];
    assign is_cfg   = word[6:0] == V_MAJOR_OP_V &&
                      word[14:12] == V_OPCFG;
    assign is_load  = word[6:0] == V_MAJOR_LOAD_FP &&
                      word[14:12] == V_LOAD_F3;
    assign is_arith = word[6:0] == V_MAJOR_OP_V && !is_cfg;
    assign is_red   = is_arith &&
                      is_reduction(word[14:12], word[31:26]);
    assign is_err   = !(is_cfg || is_load || is_arith);
    assign single   = is_cfg || is_err;
    assign valid    = (state_q == SEQ_RUN) && !empty;

    // First beat reads vl live so a vsetvli retiring on the
    // previous edge is already visible; later beats use vl_q.
    always_comb begin
        vl_eff = (cnt_q == '0) ? vl : vl_q;
        beats  = (vlx_t'(vl_eff) + vlx_t'(LANES - 1)) >> LW;
        if (beats == '0)
            beats = vlx_t'(1);
        last = single || vlx_t'(cnt_q) == beats - vlx_t'(1);
        rem  = vlx_t'(vl_eff) & vlx_t'(LANES - 1);
        for (int i = 0; i < LANES; i++)
            mask[i] = !last || rem == '0 || vlx_t'(i) < rem;
        if (single || vl_eff == '0)
            mask = '0;
        done  = valid && (!is_load || vlsu_ready);
        pop   = done && last;
        cnt_d = cnt_q;
        if (done)
            cnt_d = last ? '0 : cnt_q + BW'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE:
                if (push || !empty)
                    state_d = SEQ_RUN;
            SEQ_RUN:
                if (empty || (pop && !push &&
                              count == CW'(1)))
                    state_d = SEQ_IDLE;
            default:
                state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
            vl_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (valid && cnt_q == '0)
                vl_q <= vl;
        end
    end

    assign off = is_red ? 5'd0 : 5'(cnt_q);

    assign beat_valid      = valid;
    assign beat_first      = valid && cnt_q == '0;
    assign beat_last       = valid && last;
    assign instr_word      = valid ? word : '0;
    assign scalar_operand1 = valid ? head[63:32] : '0;
    assign scalar_operand2 = valid ? head[95:64] : '0;
    assign vd_addr         = valid ? word[11:7] + off : '0;
    assign vs1_addr        = valid ? word[19:15] + off : '0;
    assign vs2_addr        = valid ? word[24:20] + off : '0;
    assign elem_en         = valid ? mask : '0;
    assign csr_write       = valid && is_cfg;
    assign vlsu_en         = valid && is_load;
    assign apu.apu_rvalid  = pop;
    assign apu.apu_err     = pop && is_err;
    assign busy            = !empty;

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: table vectors plus
// stall, backpressure, vl-update and reset sequences.
module tb_vector_sequencer;

    logic       clk;
    logic       n_reset;
    logic [4:0] vl;
    logic       beat_valid, beat_first, beat_last;
    logic [31:0] instr_word, scalar_operand1, scalar_operand2;
    logic [4:0] vs1_addr, vs2_addr, vd_addr;
    logic [3:0] elem_en;
    logic       csr_write, vlsu_en, vlsu_ready, busy;

    vector_sequencer_if apu();

    vector_sequencer #(
        .LANES       (4),
        .VL_WIDTH    (5),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk             (clk),
        .n_reset         (n_reset),
        .apu             (apu),
        .vl              (vl),
        .beat_valid      (beat_valid),
        .beat_first      (beat_first),
        .beat_last       (beat_last),
        .instr_word      (instr_word),
        .scalar_operand1 (scalar_operand1),
        .scalar_operand2 (scalar_operand2),
        .vs1_addr        (vs1_addr),
        .vs2_addr        (vs2_addr),
        .vd_addr         (vd_addr),
        .elem_en         (elem_en),
        .csr_write       (csr_write),
        .vlsu_en         (vlsu_en),
        .vlsu_ready      (vlsu_ready),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        int          vl;
        int          nb;
        logic [3:0]  en;
        bit          red;
        bit          csr;
        bit          ld;
        bit          err;
    } vec_t;

    typedef struct {
        logic [4:0]  vd, vs1, vs2;
        logic [3:0]  en;
        logic        first, last, csr, ld, err;
        logic [31:0] w, s1, s2;
    } beat_t;

    beat_t        sb[$];
    beat_t        mb;
    vec_t         tbl[12];
    int           checks = 0;
    int           passed = 0;
    int           gaps   = 0;
    logic [127:0] mon_act, mon_exp, snap;

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h want %0h",
                     name, act, exp);
    endtask

    function automatic logic [31:0] mkw(
        logic [5:0] f6, logic [2:0] f3, logic [4:0] vs2,
        logic [4:0] vs1, logic [4:0] vd, logic [6:0] op);
        return {f6, 1'b1, vs2, vs1, f3, vd, op};
    endfunction

    function automatic vec_t mk(
        logic [31:0] w, int v, int nb, logic [3:0] en,
        bit red, bit csr, bit ld, bit err);
        vec_t r;
        r.w = w;     r.vl = v;     r.nb = nb;  r.en = en;
        r.red = red; r.csr = csr;  r.ld = ld;  r.err = err;
        return r;
    endfunction

    function automatic void expect_vec(vec_t v);
        beat_t b;
        for (int i = 0; i < v.nb; i++) begin
            b.vd    = v.red ? v.w[11:7]  : v.w[11:7]  + 5'(i);
            b.vs1   = v.red ? v.w[19:15] : v.w[19:15] + 5'(i);
            b.vs2   = v.red ? v.w[24:20] : v.w[24:20] + 5'(i);
            b.en    = (i == v.nb - 1) ? v.en : 4'hF;
            b.first = (i == 0);
            b.last  = (i == v.nb - 1);
            b.csr   = v.csr;
            b.ld    = v.ld;
            b.err   = v.err && (i == v.nb - 1);
            b.w     = v.w;
            b.s1    = v.w ^ 32'hA5A5_0000;
            b.s2    = ~v.w;
            sb.push_back(b);
        end
    endfunction

    function automatic logic [127:0] out_all();
        return 128'({instr_word, scalar_operand1,
                     scalar_operand2, vd_addr, vs1_addr,
                     vs2_addr, elem_en, beat_valid,
                     beat_first, beat_last, csr_write,
                     vlsu_en, busy, apu.apu_rvalid,
                     apu.apu_err, apu.apu_gnt});
    endfunction

    // Called just after a rising edge; returns just after
    // the edge that accepted the instruction.
    task automatic send(input vec_t v, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        apu.apu_req = 1'b1;
        apu.apu_operands[0] = v.w;
        apu.apu_operands[1] = v.w ^ 32'hA5A5_0000;
        apu.apu_operands[2] = ~v.w;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (apu.apu_gnt) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        @(posedge clk);
        #1;
        apu.apu_req = 1'b0;
        if (ok)
            expect_vec(v);
        else
            chk("gnt_timeout", 128'(apu.apu_gnt), 128'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (sb.size() == 0)
                break;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 128'(sb.size()), 128'(0));
            sb.delete();
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (n_reset) begin
            if (beat_valid && (!vlsu_en || vlsu_ready)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 128'(beat_valid),
                        128'(0));
                end else begin
                    mb = sb.pop_front();
                    mon_act = 128'({vd_addr, vs1_addr, vs2_addr,
                        elem_en, beat_first, beat_last,
                        csr_write, vlsu_en, apu.apu_rvalid,
                        apu.apu_err, instr_word,
                        scalar_operand1, scalar_operand2});
                    mon_exp = 128'({mb.vd, mb.vs1, mb.vs2,
                        mb.en, mb.first, mb.last, mb.csr,
                        mb.ld, mb.last, mb.err, mb.w, mb.s1,
                        mb.s2});
                    chk("beat", mon_act, mon_exp);
                end
            end else begin
                chk("idle_rvalid",
                    128'({apu.apu_rvalid, apu.apu_err}),
                    128'(0));
                if (!beat_valid && sb.size() != 0)
                    gaps++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t va, vb, vc, vx;
        int   w0, w1, w2, n;

        n_reset          = 1'b0;
        vl               = '0;
        vlsu_ready       = 1'b1;
        apu.apu_req      = 1'b0;
        apu.apu_operands = '0;

        tbl[0]  = mk(mkw(6'h00, 3'b000, 5'd4, 5'd12, 5'd8,
                         7'h57), 10, 3, 4'b0011, 0, 0, 0, 0);
        tbl[1]  = mk(mkw(6'h00, 3'b000, 5'd1, 5'd2, 5'd3,
                         7'h57), 8, 2, 4'b1111, 0, 0, 0, 0);
        tbl[2]  = mk(mkw(6'h00, 3'b000, 5'd5, 5'd6, 5'd7,
                         7'h57), 0, 1, 4'b0000, 0, 0, 0, 0);
        tbl[3]  = mk(mkw(6'h00, 3'b010, 5'd6, 5'd3, 5'd2,
                         7'h57), 5, 2, 4'b0001, 1, 0, 0, 0);
        tbl[4]  = mk(mkw(6'h00, 3'b000, 5'd1, 5'd1, 5'd1,
                         7'h33), 10, 1, 4'b0000, 0, 0, 0, 1);
        tbl[5]  = mk(mkw(6'h07, 3'b010, 5'd9, 5'd10, 5'd11,
                         7'h57), 4, 1, 4'b1111, 1, 0, 0, 0);
        tbl[6]  = mk(mkw(6'h31, 3'b000, 5'd20, 5'd21, 5'd22,
                         7'h57), 9, 3, 4'b0001, 1, 0, 0, 0);
        tbl[7]  = mk(mkw(6'h00, 3'b000, 5'd31, 5'd28, 5'd30,
                         7'h57), 31, 8, 4'b0111, 0, 0, 0, 0);
        tbl[8]  = mk(mkw(6'h07, 3'b000, 5'd1, 5'd2, 5'd3,
                         7'h57), 6, 2, 4'b0011, 0, 0, 0, 0);
        tbl[9]  = mk(mkw(6'h00, 3'b000, 5'd13, 5'd14, 5'd15,
                         7'h57), 1, 1, 4'b0001, 0, 0, 0, 0);
        tbl[10] = mk(mkw(6'h00, 3'b111, 5'd3, 5'd4, 5'd5,
                         7'h57), 20, 1, 4'b0000, 0, 1, 0, 0);
        tbl[11] = mk(mkw(6'h00, 3'b111, 5'd0, 5'd10, 5'd16,
                         7'h07), 3, 1, 4'b0111, 0, 0, 1, 0);

        #2;
        chk("reset_outputs", out_all(), 128'd1);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        #1;
        chk("reset_release", out_all(), 128'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            vl = 5'(tbl[i].vl);
            send(tbl[i], w0);
            drain();
        end

        // load stalled on its first beat for three cycles
        vx = mk(mkw(6'h00, 3'b111, 5'd0, 5'd20, 5'd5,
                    7'h07), 6, 2, 4'b0011, 0, 0, 1, 0);
        vl = 5'd6;
        vlsu_ready = 1'b0;
        send(vx, w0);
        @(negedge clk);
        snap = out_all();
        chk("stall_beat",
            128'({beat_valid, vlsu_en, beat_first}),
            128'(3'b111));
        repeat (2) begin
            @(negedge clk);
            chk("stall_hold", out_all(), snap);
        end
        @(posedge clk);
        #1;
        vlsu_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (apu.apu_rvalid)
                break;
        end
        chk("stall_rvalid_cycle", 128'(n + 3), 128'(vx.nb + 3));
        drain();

        // three requests against a two-entry queue
        vl = 5'd10;
        va = mk(mkw(6'h00, 3'b000, 5'd1, 5'd2, 5'd3,
                    7'h57), 10, 3, 4'b0011, 0, 0, 0, 0);
        vb = mk(mkw(6'h00, 3'b000, 5'd4, 5'd5, 5'd6,
                    7'h57), 10, 3, 4'b0011, 0, 0, 0, 0);
        vc = mk(mkw(6'h00, 3'b000, 5'd7, 5'd8, 5'd9,
                    7'h57), 10, 3, 4'b0011, 0, 0, 0, 0);
        send(va, w0);
        send(vb, w1);
        send(vc, w2);
        chk("gnt_first_two", 128'(w0 + w1), 128'(0));
        chk("gnt_wait_third", 128'(w2), 128'(va.nb - 1));
        drain();

        // vl rewritten at the vsetvli completion edge
        vl = 5'd4;
        va = mk(mkw(6'h00, 3'b111, 5'd1, 5'd1, 5'd1,
                    7'h57), 4, 1, 4'b0000, 0, 1, 0, 0);
        vb = mk(mkw(6'h00, 3'b000, 5'd10, 5'd11, 5'd12,
                    7'h57), 7, 2, 4'b0111, 0, 0, 0, 0);
        send(va, w0);
        send(vb, w1);
        vl = 5'd7;
        drain();

        // reset in the middle of a beat with a second entry queued
        vl = 5'd10;
        send(mk(mkw(6'h00, 3'b000, 5'd2, 5'd2, 5'd2, 7'h57),
                10, 3, 4'b0011, 0, 0, 0, 0), w0);
        send(mk(mkw(6'h00, 3'b000, 5'd3, 5'd3, 5'd3, 7'h57),
                10, 3, 4'b0011, 0, 0, 0, 0), w1);
        #2;
        chk("midbeat_valid", 128'(beat_valid), 128'(1));
        n_reset = 1'b0;
        #1;
        chk("midbeat_reset", out_all(), 128'd1);
        sb.delete();
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        #1;
        chk("post_reset_idle", out_all(), 128'd1);
        repeat (5) @(negedge clk);
        chk("post_reset_busy", 128'(busy), 128'(0));

        drain();
        chk("no_bubble", 128'(gaps), 128'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vector_sequencer.md
# vector_sequencer

Parametrised instruction sequencer for the vector accelerator. It accepts instructions from the core's APU interface into a small queue, so a new instruction can be granted while the current one executes. It expands each queued instruction into one or more beats of LANES elements, producing per-beat register addresses, an element-enable mask and the APU completion handshake. It sits between the APU interface and the vector decode/datapath, and stalls on the vector load/store unit.

## Interface
- LANES, 4, elements processed per beat; power of two, 1..8
- VL_WIDTH, 5, width of the vl CSR
- QUEUE_DEPTH, 2, instruction queue entries; at least 1
- clk  in  1  clock
- n_reset  in  1  asynchronous, active-low reset
- apu_req  in  1  instruction offered
- apu_gnt  out  1  queue can accept this cycle
- apu_operands  in  3x32  [0] instruction word, [1]/[2] scalar operands
- apu_rvalid  out  1  one-cycle completion pulse
- apu_err  out  1  qualifies apu_rvalid; unrecognised major opcode
- vl  in  VL_WIDTH  current vector length
- beat_valid  out  1  a beat is presented this cycle
- beat_first, beat_last  out  1  first/last beat of the instruction
- instr_word  out  32  head instruction word, for downstream decode
- scalar_operand1/2  out  32  head scalar operands
- vs1_addr, vs2_addr, vd_addr  out  5  per-beat register addresses
- elem_en  out  LANES  lane enable mask for this beat
- csr_write  out  1  vsetvli beat
- vlsu_en  out  1  load beat in progress
- vlsu_ready  in  1  VLSU accepts the beat
- busy  out  1  queue not empty

## Operation
- Enqueue: when apu_req && apu_gnt, operands[0..2] are pushed. apu_gnt = (count < QUEUE_DEPTH). There is no bypass when full.
- Head classification:
  - major 7'h57 with funct3 3'b111: config. One beat, csr_write=1, elem_en=0.
  - major 7'h07 with funct3 3'b111: load. Multi-beat, vlsu_en=1 on every beat.
  - major 7'h57 otherwise: arithmetic. Multi-beat.
  - Reduction: funct3 3'b010 with funct6 000000 or 000111, or funct6 110001. Addresses are held fixed and are not incremented.
  - Any other major opcode: one beat, elem_en=0, apu_err=1 with apu_rvalid.
- State machine:
  - IDLE → RUN when the queue is non-empty. vl is sampled into a register on entry and held for the whole instruction.
  - beats = max(1, ceil(vl_s/LANES)).
  - RUN → IDLE, or RUN with the next head, after the last beat completes.
- Addresses: the field value plus the beat index, modulo 32. Reductions use the field value only.
- elem_en:
  - All ones on non-last beats.
  - On the last beat, the low r bits are set, where r = vl_s mod LANES. r=0 means all LANES bits.
  - If vl_s=0, elem_en=0 for the single beat.
- A beat completes when beat_valid && (!vlsu_en || vlsu_ready). When a beat stalls, every beat output is held stable.
- When the last beat completes: apu_rvalid pulses, the head is popped, and the beat counter clears.
- Simultaneous push and pop are both honoured; count is unchanged.

## Timing
- Reset values:
  - All outputs 0, except apu_gnt=1.
  - Queue empty, state IDLE, beat counter 0.
- Latency:
  - An instruction accepted at edge N presents its first beat in cycle N+1 if the queue was empty.
  - apu_rvalid is asserted combinationally in the cycle the last beat completes.
- Back-to-back: the next queued instruction's first beat follows the previous last beat in the immediately following cycle, with no bubble. vl is re-sampled at that point, so a vsetvli result written at the completion edge is seen.
- Beat counter width: $clog2(ceil((2**VL_WIDTH-1)/LANES))+1.
- A reset mid-instruction discards the queue and the in-flight instruction. No apu_rvalid is produced for them.

## Structure
- Shared package holds:
  - Opcode/funct3 constants: V_MAJOR_OP_V, V_MAJOR_LOAD_FP, V_OPCFG, V_OPMVV.
  - Reduction funct6 constants.
  - seq_state_t {SEQ_IDLE, SEQ_RUN}.
- One sub-module: vector_instr_fifo, a parametrised 96-bit-wide synchronous FIFO providing full, empty and count.
- Classification, beat counter and mask generation stay in vector_sequencer.

## Test plan
All scenarios use LANES=4, VL_WIDTH=5, QUEUE_DEPTH=2.

- vadd.vv, vl=10, vd=8, vs2=4, vs1=12 → 3 beats. vd_addr 8,9,10; vs1_addr 12,13,14. elem_en 1111,1111,0011. apu_rvalid on beat 3 only.
- vl=8 vadd → 2 beats, last elem_en=1111. vl=0 → 1 beat, elem_en=0000, rvalid.
- vredsum (funct6 000000, funct3 010), vl=5, vd=2 → 2 beats. vd_addr stays 2, elem_en 1111,0001.
- Load with vl=6, vlsu_ready low for 3 cycles on beat 1 → outputs frozen, beat 2 follows, rvalid delayed by 3 cycles. Major opcode 7'h33 → single beat, apu_rvalid with apu_err=1.
- apu_req held with 3 instructions during a 3-beat op → first two granted, apu_gnt=0 until the first pop. The executions run back-to-back with no idle cycle.
- vsetvli then vadd queued, vl changing 4→7 at the vsetvli completion edge → vadd runs 2 beats with elem_en 1111,0111. n_reset asserted mid-beat → all outputs at reset values, busy=0.
